// File: rtl/axis_meta_pkg.sv
// Shared framing types for the parser-to-deframer metadata stream.
package axis_meta_pkg;

  localparam int DATA_W = 512;
  localparam int META_W = 356;

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} dfrm_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry skid buffer: 1-cycle latency, s_ready depends only on occupancy, never on m_ready.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign m_data  = slot[rd_ptr];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= s_data;
        wr_ptr       <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axis_meta_deframer.sv
// Splits header beats onto a metadata channel and forwards payload with 1-cycle latency;
// header accept stalls while the metadata slot is full, payload accept stalls on a full skid.
module axis_meta_deframer #(
  parameter int DATA_W    = axis_meta_pkg::DATA_W,
  parameter int META_W    = axis_meta_pkg::META_W,
  parameter int MAX_BEATS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [META_W-1:0] meta_tdata,
  output logic              meta_tvalid,
  input  logic              meta_tready,
  output logic [15:0]       err_cnt,
  output logic              pad_err
);

  import axis_meta_pkg::*;

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BEATS - 1);

  dfrm_state_t   state;
  logic [CW-1:0] beat_cnt;
  logic          acc;
  logic          push;
  logic          skid_ready;
  logic          last_slot;
  logic          pad_nz;
  logic          err_inc;
  axis_beat_t    push_beat;
  axis_beat_t    out_beat;

  assign last_slot = (beat_cnt == LAST_IDX);
  assign pad_nz    = |s_tdata[DATA_W-1:META_W];

  always_comb begin
    s_tready = 1'b0;
    err_inc  = 1'b0;
    case (state)
      HDR:     s_tready = !meta_tvalid || meta_tready;
      PAYLOAD: s_tready = skid_ready;
      DROP:    s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase
    acc = s_tvalid && s_tready;
    case (state)
      HDR:     err_inc = acc && (s_tlast || !s_tuser);
      PAYLOAD: err_inc = acc && (s_tuser || (!s_tlast && last_slot));
      default: err_inc = 1'b0;
    endcase
    push           = acc && (state == PAYLOAD) && !s_tuser;
    // The beat filling the last slot closes the packet even without TLAST.
    push_beat.last = s_tlast || last_slot;
    push_beat.data = s_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HDR;
      beat_cnt    <= '0;
      meta_tdata  <= '0;
      meta_tvalid <= 1'b0;
      err_cnt     <= 16'd0;
      pad_err     <= 1'b0;
    end else begin
      if (err_inc && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (meta_tvalid && meta_tready) begin
        meta_tvalid <= 1'b0;
      end
      case (state)
        HDR: begin
          if (acc && s_tuser) begin
            if (pad_nz) begin
              pad_err <= 1'b1;
            end
            if (!s_tlast) begin
              meta_tdata  <= s_tdata[META_W-1:0];
              meta_tvalid <= 1'b1;
              beat_cnt    <= '0;
              state       <= PAYLOAD;
            end
          end else if (acc && !s_tlast) begin
            state <= DROP;
          end
        end
        PAYLOAD: begin
          if (push) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_tlast) begin
              state <= HDR;
            end else if (last_slot) begin
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (acc && s_tlast) begin
            state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

  axis_skid_buf #(
    .W ($bits(axis_beat_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (push_beat),
    .s_valid (push),
    .s_ready (skid_ready),
    .m_data  (out_beat),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );

  assign m_tdata = out_beat.data;
  assign m_tlast = out_beat.last;

endmodule

// File: tb/tb_axis_meta_deframer.sv
// Randomised and directed bench for axis_meta_deframer against a beat-level framing model.
module tb_axis_meta_deframer;

  import axis_meta_pkg::*;

  localparam int MAXB = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic              s_tuser = 1'b0;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              m_tlast;
  logic [META_W-1:0] meta_tdata;
  logic              meta_tvalid;
  logic              meta_tready = 1'b1;
  logic [15:0]       err_cnt;
  logic              pad_err;

  axis_meta_deframer #(
    .DATA_W    (DATA_W),
    .META_W    (META_W),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .meta_tdata  (meta_tdata),
    .meta_tvalid (meta_tvalid),
    .meta_tready (meta_tready),
    .err_cnt     (err_cnt),
    .pad_err     (pad_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W:0]   exp_m[$];
  logic [DATA_W:0]   got_m[$];
  logic [META_W-1:0] exp_meta[$];
  logic [META_W-1:0] got_meta[$];

  // Reference model: where we are in the packet framing, by plain flags and a beat count.
  bit          mdl_in_pkt;
  bit          mdl_drop;
  int          mdl_n;
  logic [15:0] mdl_err;
  logic        mdl_pad;

  int m_mode     = 0;
  int meta_hold  = 0;
  bit meta_block = 1'b0;
  bit meta_rand  = 1'b0;

  task automatic check(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_hdr();
    logic [DATA_W-1:0] r;
    r = rand_data();
    r[DATA_W-1:META_W] = '0;
    return r;
  endfunction

  task automatic model_reset();
    mdl_in_pkt = 1'b0;
    mdl_drop   = 1'b0;
    mdl_n      = 0;
    mdl_err    = 16'd0;
    mdl_pad    = 1'b0;
  endtask

  task automatic bump_err();
    if (mdl_err != 16'hFFFF) mdl_err = mdl_err + 16'd1;
  endtask

  task automatic model_beat(input logic u, input logic l, input logic [DATA_W-1:0] d);
    if (mdl_drop) begin
      if (l) mdl_drop = 1'b0;
    end else if (mdl_in_pkt) begin
      if (u) begin
        bump_err();
      end else begin
        mdl_n++;
        exp_m.push_back({l || (mdl_n == MAXB), d});
        if (l) begin
          mdl_in_pkt = 1'b0;
        end else if (mdl_n == MAXB) begin
          bump_err();
          mdl_in_pkt = 1'b0;
          mdl_drop   = 1'b1;
        end
      end
    end else if (u) begin
      if (d[DATA_W-1:META_W] != '0) mdl_pad = 1'b1;
      if (l) begin
        bump_err();
      end else begin
        exp_meta.push_back(d[META_W-1:0]);
        mdl_in_pkt = 1'b1;
        mdl_n      = 0;
      end
    end else begin
      bump_err();
      if (!l) mdl_drop = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    case (m_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = !m_tready;
      2:       m_tready = ($urandom_range(0, 1) == 1);
      default: m_tready = 1'b0;
    endcase
    if (meta_hold > 0) begin
      meta_tready = 1'b0;
      meta_hold--;
    end else if (meta_block) begin
      meta_tready = 1'b0;
    end else if (meta_rand) begin
      meta_tready = ($urandom_range(0, 1) == 1);
    end else begin
      meta_tready = 1'b1;
    end
  end

  // Output collector and stall-stability checks, sampled just before each rising edge.
  bit                stall_m    = 1'b0;
  bit                stall_meta = 1'b0;
  logic [DATA_W:0]   prev_m;
  logic [META_W-1:0] prev_meta;

  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (stall_m) begin
        check("m_hold_vld", m_tvalid, 1);
        check("m_hold_dat", {m_tlast, m_tdata}, prev_m);
      end
      if (stall_meta) begin
        check("meta_hold_vld", meta_tvalid, 1);
        check("meta_hold_dat", meta_tdata, prev_meta);
      end
      if (m_tvalid && m_tready) got_m.push_back({m_tlast, m_tdata});
      if (meta_tvalid && meta_tready) got_meta.push_back(meta_tdata);
      stall_m    = m_tvalid && !m_tready;
      stall_meta = meta_tvalid && !meta_tready;
      prev_m     = {m_tlast, m_tdata};
      prev_meta  = meta_tdata;
    end else begin
      stall_m    = 1'b0;
      stall_meta = 1'b0;
    end
  end

  task automatic send_beat(input logic u, input logic l, input logic [DATA_W-1:0] d);
    logic ok;
    ok       = 1'b0;
    s_tvalid = 1'b1;
    s_tuser  = u;
    s_tlast  = l;
    s_tdata  = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      #4;
      if (s_tready) begin
        ok = 1'b1;
        if (u && !l && !mdl_in_pkt && !mdl_drop)
          check("hdr_slot_free", !(meta_tvalid && !meta_tready), 1);
        model_beat(u, l, d);
      end
      @(negedge clk);
    end
    check("accept_timeout", ok, 1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain_and_check(input string tag);
    m_mode     = 0;
    meta_hold  = 0;
    meta_block = 1'b0;
    meta_rand  = 1'b0;
    idle(12);
    check({tag, "_m_count"}, got_m.size(), exp_m.size());
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
      check({tag, "_m_beat"}, got_m[i], exp_m[i]);
    check({tag, "_meta_count"}, got_meta.size(), exp_meta.size());
    for (int i = 0; i < exp_meta.size() && i < got_meta.size(); i++)
      check({tag, "_meta"}, got_meta[i], exp_meta[i]);
    check({tag, "_err_cnt"}, err_cnt, mdl_err);
    check({tag, "_pad_err"}, pad_err, mdl_pad);
    exp_m.delete();
    got_m.delete();
    exp_meta.delete();
    got_meta.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_meta_tvalid"}, meta_tvalid, 0);
    check({tag, "_meta_tdata"}, meta_tdata, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_pad_err"}, pad_err, 0);
  endtask

  task automatic good_packet(input int len);
    send_beat(1'b1, 1'b0, rand_hdr());
    for (int b = 1; b <= len; b++) begin
      if (m_mode == 2) idle($urandom_range(0, 1));
      send_beat(1'b0, b == len, rand_data());
    end
  endtask

  initial begin
    logic [DATA_W-1:0] hd;
    int                kind;

    model_reset();
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Nominal packet, all ready, with 1-cycle payload latency check.
    hd = '0;
    hd[11:0] = 12'hABC;
    send_beat(1'b1, 1'b0, hd);
    hd = '0;
    hd[0] = 1'b1;
    send_beat(1'b0, 1'b0, hd);
    check("lat_vld", m_tvalid, 1);
    check("lat_dat", {m_tlast, m_tdata}, {1'b0, hd});
    hd = '0;
    hd[1] = 1'b1;
    send_beat(1'b0, 1'b0, hd);
    hd[0] = 1'b1;
    send_beat(1'b0, 1'b1, hd);
    drain_and_check("nominal");

    // Back-pressure on both output channels.
    m_mode    = 1;
    meta_hold = 5;
    good_packet(3);
    good_packet(2);
    drain_and_check("backpressure");

    // Orphan payload followed by a good packet.
    send_beat(1'b0, 1'b0, rand_data());
    send_beat(1'b0, 1'b1, rand_data());
    good_packet(2);
    drain_and_check("orphan");

    // Overlong packet truncated at MAX_BEATS.
    good_packet(5);
    drain_and_check("overlong");

    // Nonzero pad bits, then a stray header in the middle of a packet.
    hd = rand_hdr();
    hd[400] = 1'b1;
    send_beat(1'b1, 1'b0, hd);
    send_beat(1'b0, 1'b0, rand_data());
    send_beat(1'b1, 1'b0, rand_hdr());
    send_beat(1'b0, 1'b0, rand_data());
    send_beat(1'b0, 1'b1, rand_data());
    drain_and_check("midhdr_pad");

    // Random framing mix under random readiness.
    for (int p = 0; p < 40; p++) begin
      m_mode    = 2;
      meta_rand = 1'b1;
      kind      = $urandom_range(0, 9);
      if (kind <= 6) begin
        good_packet($urandom_range(1, 5));
      end else if (kind == 7) begin
        send_beat(1'b0, 1'b0, rand_data());
        send_beat(1'b0, 1'b1, rand_data());
      end else if (kind == 8) begin
        send_beat(1'b1, 1'b1, rand_hdr());
      end else begin
        send_beat(1'b1, 1'b0, rand_hdr());
        send_beat(1'b0, 1'b0, rand_data());
        send_beat(1'b1, 1'b0, rand_hdr());
        send_beat(1'b0, 1'b1, rand_data());
      end
      idle($urandom_range(0, 2));
    end
    drain_and_check("random");

    // Reset in the middle of a packet with both output channels holding data.
    m_mode     = 3;
    meta_block = 1'b1;
    send_beat(1'b1, 1'b0, rand_hdr());
    send_beat(1'b0, 1'b0, rand_data());
    check("pre_rst_m_tvalid", m_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    exp_m.delete();
    got_m.delete();
    exp_meta.delete();
    got_meta.delete();
    @(negedge clk);
    rst        = 1'b0;
    m_mode     = 0;
    meta_block = 1'b0;
    idle(1);
    send_beat(1'b0, 1'b0, rand_data());
    send_beat(1'b0, 1'b1, rand_data());
    good_packet(3);
    drain_and_check("post_rst");

    // Error counter saturation.
    force dut.err_cnt = 16'hFFFF;
    mdl_err = 16'hFFFF;
    send_beat(1'b0, 1'b1, rand_data());
    release dut.err_cnt;
    send_beat(1'b0, 1'b1, rand_data());
    idle(1);
    check("err_sat", err_cnt, 16'hFFFF);
    drain_and_check("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
